// File: rtl/median_window5x5_pkg.sv
// Shared constants for the 5x5 median window front end.
// Holds the window geometry and the element index helper.
package median_window5x5_pkg;

    parameter int PIX_DW  = 8;
    parameter int WIN_DIM = 5;
    parameter int WIN_N   = WIN_DIM * WIN_DIM;
    parameter int WIN_CTR = (WIN_N - 1) / 2;
    parameter int LB_N    = WIN_DIM - 1;

    // Flat element index of window position (r, c); r=0 oldest line, c=0 oldest column.
    function automatic int win_idx(input int r, input int c);
        return WIN_DIM * r + c;
    endfunction

endpackage

// File: rtl/median_window5x5_line_buf_ram.sv
// Single-port line memory: registered write, asynchronous read.
// Contents are deliberately not reset.
module line_buf_ram #(
    parameter int DEPTH = 640,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/median_window5x5.sv
// Forms registered 5x5 neighbourhoods from a raster pixel stream using four
// line buffers; only windows lying fully inside the frame are strobed out.
module median_window5x5
    import median_window5x5_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = PIX_DW,
    parameter int XW    = $clog2(IMG_W),
    parameter int YW    = $clog2(IMG_H)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [DW-1:0]      in_pix,
    output logic [WIN_N*DW-1:0] win,
    output logic               win_valid,
    output logic [XW-1:0]      out_x,
    output logic [YW-1:0]      out_y,
    output logic               out_eof,
    output logic               sof_err
);

    localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] COL_MIN  = XW'(WIN_DIM - 1);
    localparam logic [YW-1:0] ROW_MIN  = YW'(WIN_DIM - 1);
    localparam logic [XW-1:0] X_OFS    = XW'(WIN_DIM / 2);
    localparam logic [YW-1:0] Y_OFS    = YW'(WIN_DIM / 2);

    // col/row hold the position expected for the next beat.
    logic [XW-1:0] col, cur_col;
    logic [YW-1:0] row, cur_row;
    logic          col_end, frame_end, win_hit, pos_zero;

    logic [LB_N-1:0][DW-1:0]    lb_rd, lb_wr;
    logic [WIN_DIM-1:0][DW-1:0] col_vec;
    logic [WIN_N-1:0][DW-1:0]   win_q;

    assign cur_col   = in_sof ? '0 : col;
    assign cur_row   = in_sof ? '0 : row;
    assign col_end   = (cur_col == COL_LAST);
    assign frame_end = col_end && (cur_row == ROW_LAST);
    assign win_hit   = in_valid && (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);
    assign pos_zero  = (col == '0) && (row == '0);

    // lb0 holds the newest stored line; each buffer passes its old value one line older.
    for (genvar k = 0; k < LB_N; k++) begin : g_lb
        if (k == 0) begin : g_head
            assign lb_wr[k] = in_pix;
        end else begin : g_chain
            assign lb_wr[k] = lb_rd[k-1];
        end

        line_buf_ram #(
            .DEPTH (IMG_W),
            .DW    (DW),
            .AW    (XW)
        ) u_lb (
            .clk   (clk),
            .we    (in_valid),
            .addr  (cur_col),
            .wdata (lb_wr[k]),
            .rdata (lb_rd[k])
        );
    end

    for (genvar r = 0; r < WIN_DIM; r++) begin : g_col
        if (r < LB_N) begin : g_old
            assign col_vec[r] = lb_rd[LB_N-1-r];
        end else begin : g_new
            assign col_vec[r] = in_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (col_end) begin
                col <= '0;
                row <= frame_end ? '0 : cur_row + YW'(1);
            end else begin
                col <= cur_col + XW'(1);
                row <= cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (in_valid) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM - 1; c++) begin
                    win_q[win_idx(r, c)] <= win_q[win_idx(r, c + 1)];
                end
                win_q[win_idx(r, WIN_DIM - 1)] <= col_vec[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            out_eof   <= 1'b0;
            sof_err   <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            win_valid <= win_hit;
            out_eof   <= win_hit && frame_end;
            sof_err   <= in_valid && in_sof && !pos_zero;
            if (win_hit) begin
                out_x <= cur_col - X_OFS;
                out_y <= cur_row - Y_OFS;
            end
        end
    end

    assign win = win_q;

endmodule

// File: tb/tb_median_window5x5.sv
// Directed bench for median_window5x5 on an 8x6 frame with pixel = 16*row+col.
module tb_median_window5x5;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int DW    = 8;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_sof = 1'b0;
    logic [DW-1:0]     in_pix = '0;
    logic [25*DW-1:0]  win;
    logic              win_valid;
    logic [XW-1:0]     out_x;
    logic [YW-1:0]     out_y;
    logic              out_eof;
    logic              sof_err;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    median_window5x5 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_pix    (in_pix),
        .win       (win),
        .win_valid (win_valid),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_eof   (out_eof),
        .sof_err   (sof_err)
    );

    function automatic logic [DW-1:0] pix_at(input int r, input int c);
        return DW'(16 * r + c);
    endfunction

    // Drive one beat, then sample its registered result just after the edge.
    task automatic beat(input logic sof, input logic [DW-1:0] pix);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_pix   = pix;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if ({win_valid, out_eof, sof_err, out_x, out_y} !== '0 || win !== '0) begin
            nerr++;
            $display("FAIL reset_state: valid=%b eof=%b err=%b x=%0d y=%0d win=%h, required all 0",
                     win_valid, out_eof, sof_err, out_x, out_y, win);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Full frame; every beat checked for strobe and window content.
    task automatic run_frame(input string tag, input int gap_max, input bit sof_first);
        int wins = 0;
        logic [25*DW-1:0] ewin, held;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                bit ev;
                beat(sof_first && r == 0 && c == 0, pix_at(r, c));
                ev = (r >= 4 && c >= 4);
                nvec++;
                if (win_valid !== ev || sof_err !== 1'b0) begin
                    nerr++;
                    $display("FAIL %s strobe(%0d,%0d): valid=%b err=%b, required valid=%b err=0",
                             tag, r, c, win_valid, sof_err, ev);
                end
                if (ev) begin
                    wins++;
                    for (int i = 0; i < 25; i++)
                        ewin[DW*i +: DW] = pix_at(r - 4 + i / 5, c - 4 + i % 5);
                    nvec++;
                    if (win !== ewin || out_x !== XW'(c - 2) || out_y !== YW'(r - 2) ||
                        out_eof !== (r == IMG_H - 1 && c == IMG_W - 1)) begin
                        nerr++;
                        $display("FAIL %s window(%0d,%0d): win=%h x=%0d y=%0d eof=%b, required win=%h x=%0d y=%0d",
                                 tag, r, c, win, out_x, out_y, out_eof, ewin, c - 2, r - 2);
                    end
                end
                if (r == 4 && c == 4) begin
                    nvec++;
                    if (win[7:0] !== 8'h00 || win[12*DW +: DW] !== 8'h22 ||
                        win[24*DW +: DW] !== 8'h44 || out_x !== 3'd2 || out_y !== 3'd2) begin
                        nerr++;
                        $display("FAIL %s first_window: e0=%h e12=%h e24=%h x=%0d y=%0d, required 00 22 44 x=2 y=2",
                                 tag, win[7:0], win[12*DW +: DW], win[24*DW +: DW], out_x, out_y);
                    end
                end
                if (r == IMG_H - 1 && c == IMG_W - 1) begin
                    nvec++;
                    if (out_eof !== 1'b1 || out_x !== 3'd5 || out_y !== 3'd3) begin
                        nerr++;
                        $display("FAIL %s last_window: eof=%b x=%0d y=%0d, required eof=1 x=5 y=3",
                                 tag, out_eof, out_x, out_y);
                    end
                end
                held = win;
                repeat ($urandom_range(0, gap_max)) begin
                    idle_cycle();
                    nvec++;
                    if (win_valid !== 1'b0 || out_eof !== 1'b0 || sof_err !== 1'b0 || win !== held) begin
                        nerr++;
                        $display("FAIL %s gap_hold(%0d,%0d): valid=%b eof=%b err=%b win_changed=%b, required 0 0 0 0",
                                 tag, r, c, win_valid, out_eof, sof_err, win !== held);
                    end
                end
            end
        end
        idle_cycle();
        nvec++;
        if (wins != 8) begin
            nerr++;
            $display("FAIL %s window_count: got %0d, required 8", tag, wins);
        end
    endtask

    task automatic test_full_frame();
        run_frame("full_frame", 0, 1'b1);
    endtask

    task automatic test_gaps();
        run_frame("gaps", 3, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_first", 0, 1'b1);
        run_frame("b2b_second", 0, 1'b0);
    endtask

    // Restart at expected position (2,3); sof beat becomes the new (0,0).
    task automatic test_sof_err();
        int seen_at = -1;
        for (int i = 0; i < 2 * IMG_W + 3; i++) begin
            beat(1'b0, 8'hAA);
            nvec++;
            if (sof_err !== 1'b0 || win_valid !== 1'b0) begin
                nerr++;
                $display("FAIL sof_pre beat %0d: err=%b valid=%b, required 0 0", i, sof_err, win_valid);
            end
        end
        beat(1'b1, pix_at(0, 0));
        nvec++;
        if (sof_err !== 1'b1 || win_valid !== 1'b0) begin
            nerr++;
            $display("FAIL sof_err_pulse: err=%b valid=%b, required err=1 valid=0", sof_err, win_valid);
        end
        for (int n = 1; n <= 36; n++) begin
            beat(1'b0, pix_at(n / IMG_W, n % IMG_W));
            if (win_valid === 1'b1 && seen_at < 0) seen_at = n;
            nvec++;
            if (sof_err !== 1'b0) begin
                nerr++;
                $display("FAIL sof_err_once beat %0d: err=%b, required 0", n, sof_err);
            end
        end
        nvec++;
        if (seen_at != 36 || out_x !== 3'd2 || out_y !== 3'd2 || win[12*DW +: DW] !== 8'h22) begin
            nerr++;
            $display("FAIL sof_restart_window: first at beat %0d x=%0d y=%0d e12=%h, required beat 36 x=2 y=2 e12=22",
                     seen_at, out_x, out_y, win[12*DW +: DW]);
        end
    endtask

    task automatic test_reset_mid();
        beat(1'b0, pix_at(4, 5));
        beat(1'b0, pix_at(4, 6));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        nvec++;
        if ({win_valid, out_eof, sof_err, out_x, out_y} !== '0 || win !== '0) begin
            nerr++;
            $display("FAIL reset_mid_during: valid=%b x=%0d y=%0d win=%h, required all 0",
                     win_valid, out_x, out_y, win);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nvec++;
        if ({win_valid, out_eof, sof_err, out_x, out_y} !== '0 || win !== '0) begin
            nerr++;
            $display("FAIL reset_mid_after: valid=%b x=%0d y=%0d win=%h, required all 0",
                     win_valid, out_x, out_y, win);
        end
        run_frame("post_reset", 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_back_to_back();
        test_sof_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
